// File: rtl/core_mc_top.sv
// core_mc_top: multicycle RV32I-subset core with one shared memory port.
// Instruction fetch and data accesses share a req/ready handshake, so the
// core tolerates any number of wait cycles. Illegal instructions halt it.
// Optional build macro CORE_SIM_TAP_EN exposes x28..x31 on sim_t3..sim_t6.
module core_mc_top #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        halted,
  output logic        retire,
  output logic [31:0] sim_t3,
  output logic [31:0] sim_t4,
  output logic [31:0] sim_t5,
  output logic [31:0] sim_t6
);

  localparam int          IW      = $clog2(NREGS);
  localparam logic [31:0] NREGS_W = 32'(NREGS);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  state_t      state, next_state, dec_state;
  logic [31:0] pc, old_pc, ir, a, b, alu_out, data, target;
  logic [31:0] regs [NREGS];
  logic [31:0] rs1_val, rs2_val, alu_res, op_b, mem_ea;
  logic        rs1_bad, rs2_bad, rd_bad;

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j  = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

  assign rs1_bad = ({27'd0, rs1} >= NREGS_W);
  assign rs2_bad = ({27'd0, rs2} >= NREGS_W);
  assign rd_bad  = ({27'd0, rd}  >= NREGS_W);

  // Register file read ports; x0 and out-of-range indices read as zero
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && !rs1_bad) rs1_val = regs[rs1[IW-1:0]];
    if (rs2 != 5'd0 && !rs2_bad) rs2_val = regs[rs2[IW-1:0]];
  end

  // Decoder: pick the execute state, or TRAP for anything unsupported
  always_comb begin
    dec_state = S_TRAP;
    case (opcode)
      OP_LOAD:  if (funct3 == 3'b010 && !rs1_bad && !rd_bad) dec_state = S_MEMADR;
      OP_STORE: if (funct3 == 3'b010 && !rs1_bad && !rs2_bad) dec_state = S_MEMADR;
      OP_REG: begin
        if (!rs1_bad && !rs2_bad && !rd_bad &&
            ((funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b111 ||
                                       funct3 == 3'b110 || funct3 == 3'b010)) ||
             (funct7 == 7'b0100000 && funct3 == 3'b000)))
          dec_state = S_EXECR;
      end
      OP_IMM: begin
        if (!rs1_bad && !rd_bad &&
            (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110 || funct3 == 3'b010))
          dec_state = S_EXECI;
      end
      OP_BR:  if (funct3 == 3'b000 && !rs1_bad && !rs2_bad) dec_state = S_BEQ;
      OP_JAL: if (!rd_bad) dec_state = S_JAL;
      default: dec_state = S_TRAP;
    endcase
  end

  // ALU for register and immediate forms; subtraction only in the R form
  always_comb begin
    op_b    = (state == S_EXECR) ? b : imm_i;
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = (state == S_EXECR && funct7[5]) ? a - op_b : a + op_b;
      3'b111:  alu_res = a & op_b;
      3'b110:  alu_res = a | op_b;
      3'b010:  alu_res = {31'd0, $signed(a) < $signed(op_b)};
      default: alu_res = '0;
    endcase
    mem_ea = a + ((opcode == OP_STORE) ? imm_s : imm_i);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  // Next state and bus outputs; everything idles while reset is held low
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    retire     = 1'b0;
    halted     = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = {pc[31:2], 2'b00};
          if (mem_ready) next_state = S_DECODE;
        end
        S_DECODE: next_state = dec_state;
        S_MEMADR: begin
          if (mem_ea[1:0] != 2'b00)  next_state = S_TRAP;
          else if (opcode == OP_STORE) next_state = S_MEMWRITE;
          else                         next_state = S_MEMREAD;
        end
        S_MEMREAD: begin
          mem_req  = 1'b1;
          mem_addr = {alu_out[31:2], 2'b00};
          if (mem_ready) next_state = S_MEMWB;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {alu_out[31:2], 2'b00};
          mem_wdata = b;
          if (mem_ready) begin
            retire     = 1'b1;
            next_state = S_FETCH;
          end
        end
        S_EXECR, S_EXECI: next_state = S_ALUWB;
        S_MEMWB, S_ALUWB, S_BEQ, S_JAL: begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_TRAP:  halted = 1'b1;
        default: next_state = S_TRAP;
      endcase
    end
  end

  // Datapath registers and register-file writeback
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      old_pc  <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      data    <= '0;
      target  <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir     <= mem_rdata;
            old_pc <= pc;
            pc     <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a      <= rs1_val;
          b      <= rs2_val;
          target <= old_pc + ((opcode == OP_JAL) ? imm_j : imm_b);
        end
        S_MEMADR:  alu_out <= mem_ea;
        S_MEMREAD: if (mem_ready) data <= mem_rdata;
        S_MEMWB:   if (rd != 5'd0) regs[rd[IW-1:0]] <= data;
        S_EXECR, S_EXECI: alu_out <= alu_res;
        S_ALUWB:   if (rd != 5'd0) regs[rd[IW-1:0]] <= alu_out;
        S_BEQ:     if (a == b) pc <= target;
        S_JAL: begin
          if (rd != 5'd0) regs[rd[IW-1:0]] <= old_pc + 32'd4;
          pc <= target;
        end
        default: ;
      endcase
    end
  end

`ifdef CORE_SIM_TAP_EN
  if (NREGS > 31) begin : g_tap
    assign sim_t3 = regs[28];
    assign sim_t4 = regs[29];
    assign sim_t5 = regs[30];
    assign sim_t6 = regs[31];
  end else begin : g_no_tap
    assign sim_t3 = '0;
    assign sim_t4 = '0;
    assign sim_t5 = '0;
    assign sim_t6 = '0;
  end
`else
  assign sim_t3 = '0;
  assign sim_t4 = '0;
  assign sim_t5 = '0;
  assign sim_t6 = '0;
`endif

endmodule

// File: tb/tb_core_mc_top.sv
// Directed testbench for core_mc_top with a wait-state configurable memory.
`timescale 1ns/1ps
module tb_core_mc_top;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, mem_ready, halted, retire;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] sim_t3, sim_t4, sim_t5, sim_t6;

  int checks = 0;
  int errors = 0;

  int progSel = 1;
  int memWait = 0;
  int waitCnt = 0;
  int doneReqs = 0;
  int stableErrs = 0;
  logic        inWait = 1'b0;
  logic [31:0] heldAddr = '0, heldData = '0;
  logic        heldWe = 1'b0;
  logic [31:0] readLog [$];
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  core_mc_top #(.RESET_PC(RESET_PC), .NREGS(32)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .retire(retire),
    .sim_t3(sim_t3), .sim_t4(sim_t4), .sim_t5(sim_t5), .sim_t6(sim_t6)
  );

  // Program images, selected per test phase
  function automatic logic [31:0] progWord(input int sel, input logic [31:0] addr);
    logic [31:0] w;
    w = '0;
    case (sel)
      1: case (addr)
           32'h100: w = 32'h0070_0293; // addi x5,x0,7
           32'h104: w = 32'h0050_0313; // addi x6,x0,5
           32'h108: w = 32'h0062_83B3; // add  x7,x5,x6
           32'h10C: w = 32'h0070_2423; // sw   x7,8(x0)
           32'h110: w = 32'h0080_2E03; // lw   x28,8(x0)
           32'h114: w = 32'h01C0_2623; // sw   x28,12(x0)
           32'h118: w = 32'hFFFF_FFFF;
           default: ;
         endcase
      2: case (addr)
           32'h100: w = 32'hF11F_F06F; // jal  x0,-240 -> 0x10
           32'h010: w = 32'h0000_0463; // beq  x0,x0,+8
           32'h014: w = 32'hFFFF_FFFF;
           32'h018: w = 32'hFF1F_F0EF; // jal  x1,-16
           32'h008: w = 32'h0010_2823; // sw   x1,16(x0)
           32'h00C: w = 32'hFFFF_FFFF;
           default: ;
         endcase
      3: if (addr == 32'h100) w = 32'h0060_2283; // lw x5,6(x0)
      4: if (addr == 32'h100) w = 32'hFFFF_FFFF;
      5: case (addr)
           32'h100: w = 32'h0080_2283; // lw x5,8(x0)
           32'h008: w = 32'h1234_5678;
           default: ;
         endcase
      6: case (addr)
           32'h100: w = 32'h0050_0E13; // addi x28,x0,5
           32'h104: w = 32'h0090_0013; // addi x0,x0,9
           32'h108: w = 32'h0000_0E33; // add  x28,x0,x0
           32'h10C: w = 32'h01C0_2A23; // sw   x28,20(x0)
           32'h110: w = 32'hFFFF_FFFF;
           32'h014: w = 32'hDEAD_BEEF;
           default: ;
         endcase
      7: case (addr)
           32'h100: w = 32'hFFD0_0293; // addi x5,x0,-3
           32'h104: w = 32'h0020_0313; // addi x6,x0,2
           32'h108: w = 32'h0062_A3B3; // slt  x7,x5,x6
           32'h10C: w = 32'h4053_0433; // sub  x8,x6,x5
           32'h110: w = 32'h0062_E4B3; // or   x9,x5,x6
           32'h114: w = 32'h0002_A593; // slti x11,x5,0
           32'h118: w = 32'h0F02_F613; // andi x12,x5,0xF0
           32'h11C: w = 32'h0270_2023; // sw   x7,32(x0)
           32'h120: w = 32'h0280_2223; // sw   x8,36(x0)
           32'h124: w = 32'h0290_2423; // sw   x9,40(x0)
           32'h128: w = 32'h02B0_2623; // sw   x11,44(x0)
           32'h12C: w = 32'h02C0_2823; // sw   x12,48(x0)
           32'h130: w = 32'hFFFF_FFFF;
           default: ;
         endcase
      default: ;
    endcase
    return w;
  endfunction

  assign mem_ready = mem_req && (waitCnt == memWait);
  assign mem_rdata = mem[mem_addr[9:2]];

  // Memory model: reloads its image in reset, inserts wait states, watches stability
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt <= 0;
      inWait  <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= progWord(progSel, 32'(i * 4));
    end else if (mem_req) begin
      if (inWait && (mem_addr != heldAddr || mem_wdata != heldData || mem_we != heldWe))
        stableErrs <= stableErrs + 1;
      if (mem_ready) begin
        waitCnt  <= 0;
        inWait   <= 1'b0;
        doneReqs <= doneReqs + 1;
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        else        readLog.push_back(mem_addr);
      end else begin
        waitCnt <= waitCnt + 1;
        if (!inWait) begin
          inWait   <= 1'b1;
          heldAddr <= mem_addr;
          heldData <= mem_wdata;
          heldWe   <= mem_we;
        end
      end
    end else begin
      waitCnt <= 0;
      inWait  <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Pulse reset with a chosen image and wait-state count, release #1 after an edge
  task automatic applyStimulus(input int sel, input int waitN);
    @(posedge clk);
    #1;
    progSel = sel;
    memWait = waitN;
    reset   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Run until halted; cycle k is sampled on the k-th negedge after release
  task automatic runProgram(input int maxCyc, input int nth, output int nthCyc, output int nRet);
    int k;
    k = 0;
    nthCyc = -1;
    nRet = 0;
    while (!halted && k < maxCyc) begin
      @(negedge clk);
      k++;
      if (retire) begin
        nRet++;
        if (nRet == nth) nthCyc = k;
      end
    end
    if (!halted) checkOutput("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkHalt(input string tag);
    int bad;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_req || retire || !halted) bad++;
    end
    checkOutput(tag, bad, 0);
  endtask

  initial begin
    int cyc, nret, base, lbase, sbase, k;

    // Zero-wait arithmetic, store and load
    applyStimulus(1, 0);
    sbase = stableErrs;
    runProgram(300, 5, cyc, nret);
    checkOutput("zw_cycles_5th_retire", cyc, 21);
    checkOutput("zw_retires", nret, 6);
    checkOutput("zw_mem8", mem[2], 32'd12);
    checkOutput("zw_x28_via_mem12", mem[3], 32'd12);
    checkOutput("zw_halted", halted, 1);
`ifdef CORE_SIM_TAP_EN
    checkOutput("zw_tap_x28", sim_t3, 32'd12);
`endif
    checkHalt("zw_halt_quiet");

    // Three wait states on each of the seven memory requests
    applyStimulus(1, 3);
    sbase = stableErrs;
    runProgram(500, 5, cyc, nret);
    checkOutput("ws_cycles_5th_retire", cyc, 21 + 3 * 7);
    checkOutput("ws_retires", nret, 6);
    checkOutput("ws_mem8", mem[2], 32'd12);
    checkOutput("ws_x28_via_mem12", mem[3], 32'd12);
    checkOutput("ws_stable", stableErrs - sbase, 0);

    // beq and jal targets
    applyStimulus(2, 0);
    lbase = readLog.size();
    runProgram(300, 1, cyc, nret);
    checkOutput("br_fetch_after_jal", readLog[lbase + 1], 32'h10);
    checkOutput("br_fetch_after_beq", readLog[lbase + 2], 32'h18);
    checkOutput("br_fetch_after_jal1", readLog[lbase + 3], 32'h08);
    checkOutput("br_x1_link", mem[4], 32'h1C);
    checkOutput("br_retires", nret, 4);

    // Misaligned load traps without a data request
    applyStimulus(3, 0);
    base = doneReqs;
    runProgram(100, 1, cyc, nret);
    checkOutput("mis_halted", halted, 1);
    checkOutput("mis_retires", nret, 0);
    checkOutput("mis_requests", doneReqs - base, 1);
    checkHalt("mis_halt_quiet");

    // Illegal word traps; a fresh reset restarts fetch at RESET_PC
    applyStimulus(4, 0);
    #1;
    checkOutput("ill_first_req", mem_req, 1);
    checkOutput("ill_first_addr", mem_addr, RESET_PC);
    runProgram(100, 1, cyc, nret);
    checkOutput("ill_halted", halted, 1);
    checkOutput("ill_retires", nret, 0);
    checkHalt("ill_halt_quiet");

    // Reset asserted while a load is waiting on memory
    applyStimulus(5, 20);
    k = 0;
    while (!(mem_req && !mem_we && mem_addr == 32'h8) && k < 60) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rst_memread_seen", mem_addr, 32'h8);
    reset = 1'b0;
    #1;
    checkOutput("rst_req_low", mem_req, 0);
    checkOutput("rst_addr_zero", mem_addr, 32'h0);
    checkOutput("rst_retire_low", retire, 0);
    memWait = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_refetch_req", mem_req, 1);
    checkOutput("rst_refetch_addr", mem_addr, RESET_PC);
    checkOutput("rst_refetch_we", mem_we, 0);
    runProgram(100, 1, cyc, nret);
    checkOutput("rst_lw_retires", nret, 1);

    // x0 discards writes; debug taps
    applyStimulus(6, 0);
    runProgram(200, 1, cyc, nret);
    checkOutput("x0_mem20", mem[5], 32'h0);
    checkOutput("x0_retires", nret, 4);
`ifdef CORE_SIM_TAP_EN
    checkOutput("tap_x28_zero", sim_t3, 32'h0);
`else
    checkOutput("tap_tied_zero", sim_t3 | sim_t4 | sim_t5 | sim_t6, 32'h0);
`endif

    // Signed compare, subtract, logic ops
    applyStimulus(7, 0);
    runProgram(300, 1, cyc, nret);
    checkOutput("alu_slt", mem[8], 32'd1);
    checkOutput("alu_sub", mem[9], 32'd5);
    checkOutput("alu_or", mem[10], 32'hFFFF_FFFF);
    checkOutput("alu_slti", mem[11], 32'd1);
    checkOutput("alu_andi", mem[12], 32'h0000_00F0);
    checkOutput("alu_retires", nret, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
